requant_stream: RTL
===================

Name: requant_stream

Overview:
Pipelined, streaming requantiser computing q = sat_OUT_W(round_or_floor((acc * scale[ch]) >>> SHIFT)) on a valid/ready stream. It holds a per-channel scale table, writable at run time, and tracks the channel index automatically. It keeps a saturating count of clamped outputs. It sits between matvec/attention accumulators and the int8 activation path, replacing per-site combinational requant instances.

Parameters:
ACC_W, 24, signed accumulator width
SCALE_W, 16, unsigned scale width (32768 = 0.5 at SHIFT=16; unity-with-shift at SHIFT=22 means >>>7)
SHIFT, 22, arithmetic right shift applied to the product, >= 1
OUT_W, 8, signed output width
NUM_CH, 8, scale-table depth, >= 2
CH_W, $clog2(NUM_CH), channel index width
SAT_CNT_W, 16, saturation counter width
DEFAULT_SCALE, 32768, reset value of every scale entry

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  input beat valid
ready_o  out  1  input beat accepted when valid_i && ready_o
acc_i  in  ACC_W  signed accumulator
last_i  in  1  last beat of row; channel counter returns to 0 after this beat
round_i  in  1  1 = round half toward +inf, 0 = floor (truncate); sampled per beat
valid_o  out  1  output beat valid
ready_i  in  1  downstream ready
q_o  out  OUT_W  signed requantised result
last_o  out  1  last_i delayed with its beat
sat_o  out  1  this beat was clamped
scale_we_i  in  1  scale table write enable
scale_addr_i  in  CH_W  write address
scale_data_i  in  SCALE_W  write data
sat_clr_i  in  1  synchronous clear of sat_cnt_o
sat_cnt_o  out  SAT_CNT_W  number of clamped beats, sticks at all-ones

Behaviour:
- Reset (async, rst_ni=0): valid_o=0, q_o=0, last_o=0, sat_o=0, sat_cnt_o=0, channel counter=0, all pipeline valids=0, every scale entry = DEFAULT_SCALE. ready_o=1 after reset.
- Three pipeline stages, latency 3 cycles from acceptance to valid_o when not stalled:
  - S1 registers acc, last, round, and scale[ch] read from the table.
  - S2 registers the product: signed(acc) * signed({1'b0,scale}), width ACC_W+SCALE_W+1, no overflow.
  - S3 adds (round ? 2^(SHIFT-1) : 0) at product width +1, shifts arithmetically by SHIFT, clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and registers q_o and sat_o.
- Stall: stall = valid_o && !ready_i. ready_o = !stall. While stalled, all stages hold and outputs stay stable. Otherwise all stages advance each cycle, and bubbles are not compacted.
- Output beat transfers on valid_o && ready_i. ready_i may toggle at any time. valid_o never drops without a transfer.
- Channel counter advances on each accepted beat:
  - last_i=1 sets it to 0.
  - Otherwise it wraps from NUM_CH-1 to 0.
  - It is not affected by stalls.
- Scale write is allowed at any time. The new value is used by beats accepted in later cycles. A beat accepted in the same cycle as a write to its channel uses the old value.
- sat_cnt_o increments on each output transfer with sat_o=1, saturating at 2^SAT_CNT_W-1. If sat_clr_i and an increment occur in the same cycle, the counter becomes 0; the clear wins and that increment is lost.
- Rounding mode travels with its beat, so mid-stream changes to round_i affect only newly accepted beats.
- Reset mid-stream discards in-flight beats.

Decomposition:
- Shared package requant_pkg: default SHIFT/SCALE constants (SHIFT_MATVEC=22, SHIFT_QK=19, SCALE_UNITY=32768), and a saturate function sat_signed(value, OUT_W).
- One sub-module, requant_scale_tbl: a register-array scale table with async reset, one write port, and one combinational read port.
- Datapath and handshake stay in requant_stream.

Test Plan:
- Defaults, scale 32768, round_i=0: acc 1024 -> q 8; -1024 -> -8; 16256 -> 127 with sat_o=0; -16384 -> -128 with sat_o=0; -1 -> -1. Each result appears exactly 3 cycles after acceptance.
- Rounding, scale 32768: acc 64 gives q 0 with round_i=0 and 1 with round_i=1. acc -64 gives -1 with round_i=0 and 0 with round_i=1. acc -1 with round_i=1 gives 0.
- Saturation: acc 100000 -> 127 with sat_o=1; -100000 -> -128 with sat_o=1; sat_cnt_o=2. Pulse sat_clr_i -> 0. Force the counter to all-ones (SAT_CNT_W=2) and confirm it sticks.
- Channel table, NUM_CH=4, scales {32768,16384,49152,8192}: six beats of acc 1024 -> 8,4,12,2,8,4. With last_i on beat 2, the sequence becomes 8,4,8,4,12,2.
- Backpressure: stream 6 beats continuously with ready_i low for cycles 4-8. Check no beat is lost or duplicated, q_o/last_o stay stable while stalled, and ready_o=0 throughout the stall.
- Write hazard: write scale[0]=16384 in the same cycle a ch0 beat of acc 1024 is accepted -> 8. The next ch0 beat -> 4. Assert rst_ni mid-stream -> valid_o=0 immediately and scales return to 32768.

Source files
------------

// File: rtl/requant_pkg.sv
// requant_pkg: shared requantiser constants and the output saturation helper
package requant_pkg;
    localparam int SHIFT_MATVEC = 22;
    localparam int SHIFT_QK     = 19;
    localparam int SCALE_UNITY  = 32768;

    // Clamp a wide signed value into the range of an out_w-bit signed number
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value, input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        return value > hi ? hi : (value < lo ? lo : value);
    endfunction
endpackage

// File: rtl/requant_scale_tbl.sv
// requant_scale_tbl: per-channel scale register array, one write port, one combinational read port
//   clk_i, rst_ni      : clock, asynchronous active-low reset (all entries -> DEFAULT_SCALE)
//   we_i/waddr_i/wdata_i : write port
//   raddr_i/rdata_o    : read port (returns the value before any same-cycle write)
module requant_scale_tbl
    import requant_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CH_W = $clog2(NUM_CH),
    parameter int SCALE_W = 16,
    parameter logic [SCALE_W-1:0] DEFAULT_SCALE = SCALE_W'(SCALE_UNITY)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  logic [CH_W-1:0]    waddr_i,
    input  logic [SCALE_W-1:0] wdata_i,
    input  logic [CH_W-1:0]    raddr_i,
    output logic [SCALE_W-1:0] rdata_o
);
    logic [SCALE_W-1:0] mem [NUM_CH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CH; i++) mem[i] <= DEFAULT_SCALE;
        end else if (we_i && 32'(waddr_i) < NUM_CH) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/requant_stream.sv
// requant_stream: 3-stage streaming requantiser q = sat(round_or_floor((acc * scale[ch]) >>> SHIFT))
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   valid_i/ready_o        : input handshake; acc_i, last_i (row end), round_i (per-beat rounding)
//   valid_o/ready_i        : output handshake; q_o, last_o, sat_o (beat was clamped)
//   scale_we_i/addr/data   : run-time scale table write
//   sat_clr_i/sat_cnt_o    : saturating count of clamped output transfers
module requant_stream
    import requant_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SCALE_W = 16,
    parameter int SHIFT = SHIFT_MATVEC,
    parameter int OUT_W = 8,
    parameter int NUM_CH = 8,
    parameter int CH_W = $clog2(NUM_CH),
    parameter int SAT_CNT_W = 16,
    parameter int DEFAULT_SCALE = SCALE_UNITY
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic                    last_i,
    input  logic                    round_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic signed [OUT_W-1:0] q_o,
    output logic                    last_o,
    output logic                    sat_o,
    input  logic                    scale_we_i,
    input  logic [CH_W-1:0]         scale_addr_i,
    input  logic [SCALE_W-1:0]      scale_data_i,
    input  logic                    sat_clr_i,
    output logic [SAT_CNT_W-1:0]    sat_cnt_o
);
    localparam int PW = ACC_W + SCALE_W + 1;
    localparam logic signed [PW:0] HALF = {{PW{1'b0}}, 1'b1} << (SHIFT - 1);

    logic                    adv;
    logic                    accept;
    logic [CH_W-1:0]         ch;
    logic [SCALE_W-1:0]      scale_rd;
    logic                    s1_v, s1_last, s1_round;
    logic signed [ACC_W-1:0] s1_acc;
    logic [SCALE_W-1:0]      s1_scale;
    logic                    s2_v, s2_last, s2_round;
    logic signed [PW-1:0]    s2_prod;
    logic signed [PW:0]      s3_sum;
    logic signed [PW:0]      s3_shr;
    logic signed [63:0]      s3_wide;
    logic signed [63:0]      s3_clamp;
    logic signed [OUT_W-1:0] s3_q;
    logic                    s3_sat;

    // The whole pipe freezes only when the output register holds an unaccepted beat
    assign adv     = !(valid_o && !ready_i);
    assign ready_o = adv;
    assign accept  = valid_i && ready_o;

    requant_scale_tbl #(
        .NUM_CH(NUM_CH),
        .CH_W(CH_W),
        .SCALE_W(SCALE_W),
        .DEFAULT_SCALE(SCALE_W'(DEFAULT_SCALE))
    ) u_tbl (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .we_i(scale_we_i),
        .waddr_i(scale_addr_i),
        .wdata_i(scale_data_i),
        .raddr_i(ch),
        .rdata_o(scale_rd)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ch <= '0;
        else if (accept) ch <= (last_i || 32'(ch) == NUM_CH - 1) ? '0 : ch + 1'b1;
    end

    always_comb begin
        s3_sum   = {s2_prod[PW-1], s2_prod} + (s2_round ? HALF : '0);
        s3_shr   = s3_sum >>> SHIFT;
        s3_wide  = 64'(s3_shr);
        s3_clamp = sat_signed(s3_wide, OUT_W);
        s3_q     = s3_clamp[OUT_W-1:0];
        s3_sat   = s3_clamp != s3_wide;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v     <= 1'b0;
            s1_acc   <= '0;
            s1_last  <= 1'b0;
            s1_round <= 1'b0;
            s1_scale <= '0;
            s2_v     <= 1'b0;
            s2_prod  <= '0;
            s2_last  <= 1'b0;
            s2_round <= 1'b0;
            valid_o  <= 1'b0;
            q_o      <= '0;
            last_o   <= 1'b0;
            sat_o    <= 1'b0;
        end else if (adv) begin
            s1_v     <= accept;
            s1_acc   <= acc_i;
            s1_last  <= last_i;
            s1_round <= round_i;
            s1_scale <= scale_rd;
            s2_v     <= s1_v;
            s2_prod  <= PW'(s1_acc) * $signed(PW'({1'b0, s1_scale}));
            s2_last  <= s1_last;
            s2_round <= s1_round;
            valid_o  <= s2_v;
            q_o      <= s3_q;
            last_o   <= s2_last;
            sat_o    <= s3_sat;
        end
    end

    // Clear beats a same-cycle increment
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sat_cnt_o <= '0;
        else if (sat_clr_i) sat_cnt_o <= '0;
        else if (valid_o && ready_i && sat_o && sat_cnt_o != '1) sat_cnt_o <= sat_cnt_o + 1'b1;
    end
endmodule
